line_burst_adapter: RTL and testbench
=====================================

LINE_BURST_ADAPTER -- requirements
Module: line_burst_adapter

Interface
REQ-001 Parameter LINE_W, default 256: cache line width in bits.
REQ-002 Parameter BEAT_W, default 64: physical memory beat width; BEATS = LINE_W/BEAT_W (4 at default), and LINE_W SHALL be an integer multiple of BEAT_W.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 mem_read  input  1  line read request from the L1 arbiter, held until mem_resp.
REQ-006 mem_write  input  1  line write request from the L1 arbiter, held until mem_resp.
REQ-007 mem_address  input  32  byte address of the requested line.
REQ-008 mem_wdata  input  LINE_W  line write data.
REQ-009 mem_resp  output  1  one-cycle completion pulse to the arbiter.
REQ-010 mem_rdata  output  LINE_W  assembled read line.
REQ-011 pmem_read  output  1  burst read request to physical memory.
REQ-012 pmem_write  output  1  burst write request to physical memory.
REQ-013 pmem_address  output  32  line-aligned burst address.
REQ-014 pmem_wdata  output  BEAT_W  current write beat.
REQ-015 pmem_rdata  input  BEAT_W  current read beat.
REQ-016 pmem_resp  input  1  beat transfer strobe; one beat moves in each cycle it is high during a burst.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, RBURST, WBURST, DONE.
REQ-018 IDLE with mem_write=1 SHALL go to WBURST at the next edge and latch mem_address and mem_wdata; mem_write SHALL take priority when mem_read and mem_write are both high.
REQ-019 IDLE with mem_read=1 and mem_write=0 SHALL go to RBURST at the next edge and latch mem_address.
REQ-020 pmem_address SHALL be the latched address with bits [4:0] forced to zero, constant for the whole burst; mem_address changes after acceptance SHALL be ignored.
REQ-021 pmem_read SHALL be 1 only in RBURST, and pmem_write SHALL be 1 only in WBURST, both decoded from state (Moore, no combinational input path).
REQ-022 A beat counter of width clog2(BEATS) SHALL reset to 0 on burst entry and increment on each pmem_resp=1 cycle in RBURST/WBURST.
REQ-023 In RBURST, each cycle with pmem_resp=1 SHALL capture pmem_rdata into line bits [BEAT_W*cnt+BEAT_W-1 : BEAT_W*cnt].
REQ-024 In WBURST, pmem_wdata SHALL equal latched line bits [BEAT_W*cnt+BEAT_W-1 : BEAT_W*cnt]; outside WBURST pmem_wdata SHALL be 0.
REQ-025 On the pmem_resp=1 cycle with cnt=BEATS-1 the FSM SHALL go to DONE and the counter SHALL wrap to 0.
REQ-026 pmem_resp=0 cycles (wait states) SHALL hold the state, counter and buffer unchanged, with no limit on stall length.
REQ-027 DONE SHALL last exactly one cycle, assert mem_resp=1, and return to IDLE; mem_resp SHALL be 0 in every other state.
REQ-028 mem_rdata SHALL present the read buffer continuously and remain stable from DONE until the next RBURST overwrites it; a write burst SHALL NOT alter it.
REQ-029 Requesters deassert in the cycle after mem_resp; a request still high in the IDLE cycle after DONE SHALL be accepted as a new request.
REQ-030 pmem_resp while in IDLE or DONE SHALL be ignored.
REQ-031 Zero-wait latency SHALL be BEATS+2 cycles from the request-sampling edge to the mem_resp cycle: 1 accept, BEATS beats, 1 DONE.

Reset
REQ-032 rst_n=0 SHALL immediately force state IDLE, counter 0, read buffer 0, latched address/data 0, and all outputs (mem_resp, mem_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata) to 0.
REQ-033 Reset asserted mid-burst SHALL abort the burst with no mem_resp and no further pmem beats; the next request after release SHALL start a fresh burst at beat 0.
REQ-034 The first edge after rst_n release SHALL be able to accept a request.

Verification
REQ-035 Read, no waits: mem_read=1, addr 0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> pmem_address 0x0000_1220, mem_rdata = {0x44..,0x33..,0x22..,0x11..}, mem_resp 6 cycles after request.
REQ-036 Write with stalls: mem_write=1, wdata = {D3,D2,D1,D0}, pmem_resp pattern 1,0,0,1,1,0,1 -> pmem_wdata D0,D1,D1,D1,D2,D3,D3, exactly one mem_resp after the 4th beat.
REQ-037 mem_read and mem_write both high -> WBURST taken, pmem_read never asserted, mem_rdata unchanged.
REQ-038 rst_n low after 2 read beats -> pmem_read drops at once, no mem_resp; next read returns all 4 new beats correctly in order.
REQ-039 Back-to-back: read, then write held high into the cycle after mem_resp -> write accepted in that IDLE cycle, pmem_address tracks the new line.
REQ-040 pmem_resp pulses in IDLE and DONE, and mem_address toggled mid-burst -> no state, counter, buffer or pmem_address change.

Source files
------------

// File: rtl/line_burst_adapter.sv
// Splits cache-line reads/writes from the L1 arbiter into BEATS-long bursts on
// physical memory, reassembling read beats into a line buffer.
//
// state  | meaning
// IDLE   | waiting for mem_read/mem_write; latches address (and data on write)
// RBURST | reading beats from pmem into the line buffer
// WBURST | writing latched line beats to pmem
// DONE   | one-cycle mem_resp pulse, then back to IDLE
module line_burst_adapter #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       mem_address,
    input  logic [LINE_W-1:0] mem_wdata,
    output logic              mem_resp,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [BEAT_W-1:0] pmem_wdata,
    input  logic [BEAT_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);
    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RBURST = 2'd1,
        WBURST = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:5]       r_addr;
    logic [LINE_W-1:0] r_wline;
    logic [LINE_W-1:0] r_rline;
    logic              w_in_burst;
    logic              w_beat;
    logic              w_last;
    logic [BEAT_W-1:0] w_wbeat;

    assign w_in_burst = (r_state == RBURST) || (r_state == WBURST);
    assign w_beat     = w_in_burst && pmem_resp;
    assign w_last     = w_beat && (r_cnt == LAST_BEAT);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (mem_write)
                    w_state_nxt = WBURST;
                else if (mem_read)
                    w_state_nxt = RBURST;
            end
            RBURST, WBURST: begin
                if (w_last)
                    w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wline <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE)
                r_cnt <= '0;
            else if (w_beat)
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (r_state == IDLE && (mem_write || mem_read))
                r_addr <= mem_address[31:5];
            if (r_state == IDLE && mem_write)
                r_wline <= mem_wdata;
        end
    end

    // Only the beat slot selected by the counter is written on each accepted read beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rline <= '0;
        end else begin
            for (int b = 0; b < BEATS; b++) begin
                if (r_state == RBURST && pmem_resp && r_cnt == CNT_W'(b))
                    r_rline[b*BEAT_W +: BEAT_W] <= pmem_rdata;
            end
        end
    end

    always_comb begin
        w_wbeat = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (r_cnt == CNT_W'(b))
                w_wbeat = r_wline[b*BEAT_W +: BEAT_W];
        end
    end

    assign mem_resp     = (r_state == DONE);
    assign mem_rdata    = r_rline;
    assign pmem_read    = (r_state == RBURST);
    assign pmem_write   = (r_state == WBURST);
    assign pmem_address = {r_addr, 5'b0_0000};
    assign pmem_wdata   = (r_state == WBURST) ? w_wbeat : '0;

endmodule

// File: tb/tb_line_burst_adapter.sv
// Bench for line_burst_adapter: fixed vectors, hand-written reset/back-to-back
// sequences and random transactions checked against a per-beat line model.
module tb_line_burst_adapter;
    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = LINE_W / BEAT_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_address;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_resp;
    logic [LINE_W-1:0] mem_rdata;
    logic              pmem_read;
    logic              pmem_write;
    logic [31:0]       pmem_address;
    logic [BEAT_W-1:0] pmem_wdata;
    logic [BEAT_W-1:0] pmem_rdata;
    logic              pmem_resp;

    int n_chk  = 0;
    int n_fail = 0;
    logic [LINE_W-1:0] model_rdata;

    typedef struct {
        bit              rd;
        bit              wr;
        logic [31:0]     addr;
        logic [LINE_W-1:0] wline;
        logic [LINE_W-1:0] rline;
        logic [31:0]     pat;
        int              plen;
        bit              toggle;
        bit              noise;
        logic [31:0]     exp_paddr;
    } vec_t;

    vec_t vecs[4];

    line_burst_adapter #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one transaction starting in an IDLE cycle; the model tracks how many
    // beats have moved and therefore which beat pmem_wdata must show and when
    // mem_resp must appear. Pattern bits give pmem_resp per burst cycle, then 1s.
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [LINE_W-1:0] wline, input logic [LINE_W-1:0] rline,
                           input logic [31:0] pat, input int plen, input bit toggle,
                           input bit noise, input logic [31:0] exp_pa, input bit chain,
                           input logic [31:0] naddr, input logic [LINE_W-1:0] nwline);
        int beat;
        int k;
        int cyc;
        bit r;
        bit is_w;
        logic [LINE_W-1:0] zero_line;
        zero_line = '0;
        is_w = wr;
        if (noise) begin
            pmem_resp  = 1'b1;
            pmem_rdata = {$urandom, $urandom};
            @(posedge clk); #1;
            pmem_resp = 1'b0;
            chk("idle_noise_read", pmem_read, 1'b0);
            chk("idle_noise_write", pmem_write, 1'b0);
            chk("idle_noise_rdata", mem_rdata, model_rdata);
        end
        chk("entry_pmem_read", pmem_read, 1'b0);
        chk("entry_mem_resp", mem_resp, 1'b0);
        mem_read    = rd;
        mem_write   = wr;
        mem_address = addr;
        mem_wdata   = wline;
        pmem_resp   = 1'b0;
        @(posedge clk); #1;
        beat = 0;
        k    = 0;
        cyc  = 0;
        while (beat < BEATS) begin
            if (cyc >= 200) begin
                chk("burst_timeout", 1'b1, 1'b0);
                break;
            end
            chk("burst_pmem_read", pmem_read, !is_w);
            chk("burst_pmem_write", pmem_write, is_w);
            chk("burst_pmem_address", pmem_address, exp_pa);
            chk("burst_mem_resp", mem_resp, 1'b0);
            chk("burst_pmem_wdata", pmem_wdata, is_w ? wline[beat*BEAT_W +: BEAT_W] : zero_line[BEAT_W-1:0]);
            if (is_w)
                chk("wburst_rdata_hold", mem_rdata, model_rdata);
            r = (k < plen) ? pat[k] : 1'b1;
            k++;
            pmem_resp  = r;
            pmem_rdata = r ? rline[beat*BEAT_W +: BEAT_W] : {$urandom, $urandom};
            if (toggle)
                mem_address = $urandom;
            @(posedge clk); #1;
            cyc++;
            if (r)
                beat++;
        end
        if (!is_w)
            model_rdata = rline;
        chk("done_mem_resp", mem_resp, 1'b1);
        chk("done_pmem_read", pmem_read, 1'b0);
        chk("done_pmem_write", pmem_write, 1'b0);
        chk("done_pmem_wdata", pmem_wdata, '0);
        chk("done_pmem_address", pmem_address, exp_pa);
        chk("done_mem_rdata", mem_rdata, model_rdata);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (chain) begin
            mem_write   = 1'b1;
            mem_address = naddr;
            mem_wdata   = nwline;
        end
        pmem_resp  = noise;
        pmem_rdata = {$urandom, $urandom};
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        chk("post_mem_resp", mem_resp, 1'b0);
        chk("post_pmem_read", pmem_read, 1'b0);
        chk("post_pmem_write", pmem_write, 1'b0);
        chk("post_mem_rdata", mem_rdata, model_rdata);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LINE_W-1:0] rl;
        logic [LINE_W-1:0] wl;
        logic [31:0]       a;
        int                sel;

        vecs[0] = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_1234, wline: '0,
                    rline: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                    pat: 32'h0, plen: 0, toggle: 1'b0, noise: 1'b0, exp_paddr: 32'h0000_1220};
        // resp pattern 1,0,0,1,1,0,1 -> wdata D0,D1,D1,D1,D2,D3,D3
        vecs[1] = '{rd: 1'b0, wr: 1'b1, addr: 32'h0000_2008,
                    wline: {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
                            64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0},
                    rline: '0, pat: 32'h59, plen: 7, toggle: 1'b0, noise: 1'b0,
                    exp_paddr: 32'h0000_2000};
        vecs[2] = '{rd: 1'b1, wr: 1'b1, addr: 32'hABCD_EF7F,
                    wline: {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                            64'hA5A5_5A5A_A5A5_5A5A, 64'h0F0F_F0F0_0F0F_F0F0},
                    rline: '0, pat: 32'h2, plen: 3, toggle: 1'b0, noise: 1'b0,
                    exp_paddr: 32'hABCD_EF60};
        vecs[3] = '{rd: 1'b1, wr: 1'b0, addr: 32'h1000_003C, wline: '0,
                    rline: {64'hCAFE_0004_CAFE_0004, 64'hCAFE_0003_CAFE_0003,
                            64'hCAFE_0002_CAFE_0002, 64'hCAFE_0001_CAFE_0001},
                    pat: 32'h0A, plen: 4, toggle: 1'b1, noise: 1'b1,
                    exp_paddr: 32'h1000_0020};

        rst_n       = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        pmem_rdata  = '0;
        pmem_resp   = 1'b0;
        model_rdata = '0;
        #1;
        chk("rst_mem_resp", mem_resp, 1'b0);
        chk("rst_mem_rdata", mem_rdata, '0);
        chk("rst_pmem_read", pmem_read, 1'b0);
        chk("rst_pmem_write", pmem_write, 1'b0);
        chk("rst_pmem_address", pmem_address, '0);
        chk("rst_pmem_wdata", pmem_wdata, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++)
            run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wline, vecs[i].rline,
                    vecs[i].pat, vecs[i].plen, vecs[i].toggle, vecs[i].noise,
                    vecs[i].exp_paddr, 1'b0, 32'h0, '0);

        // Back-to-back: write held high in the IDLE cycle right after a read's DONE.
        rl = {64'h7777_0004_0000_0000, 64'h7777_0003_0000_0000,
              64'h7777_0002_0000_0000, 64'h7777_0001_0000_0000};
        wl = {64'h9999_0004_0000_0000, 64'h9999_0003_0000_0000,
              64'h9999_0002_0000_0000, 64'h9999_0001_0000_0000};
        run_txn(1'b1, 1'b0, 32'h0000_4010, '0, rl, 32'h0, 0, 1'b0, 1'b0,
                32'h0000_4000, 1'b1, 32'h0000_5095, wl);
        run_txn(1'b0, 1'b1, 32'h0000_5095, wl, '0, 32'h0, 0, 1'b0, 1'b0,
                32'h0000_5080, 1'b0, 32'h0, '0);

        // Reset two beats into a read burst.
        mem_read    = 1'b1;
        mem_address = 32'h0000_8040;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            pmem_resp  = 1'b1;
            pmem_rdata = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        chk("pre_abort_pmem_read", pmem_read, 1'b1);
        rst_n = 1'b0;
        #1;
        model_rdata = '0;
        chk("abort_pmem_read", pmem_read, 1'b0);
        chk("abort_mem_rdata", mem_rdata, '0);
        chk("abort_pmem_address", pmem_address, '0);
        mem_read = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("abort_mem_resp", mem_resp, 1'b0);
            chk("abort_hold_pmem_read", pmem_read, 1'b0);
        end
        pmem_resp = 1'b0;
        rst_n     = 1'b1;
        rl = {64'hBEEF_0004_1234_5678, 64'hBEEF_0003_1234_5678,
              64'hBEEF_0002_1234_5678, 64'hBEEF_0001_1234_5678};
        run_txn(1'b1, 1'b0, 32'h0000_9044, '0, rl, 32'h0, 0, 1'b0, 1'b0,
                32'h0000_9040, 1'b0, 32'h0, '0);

        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 2);
            a   = $urandom;
            rl  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            wl  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_txn(sel != 1, sel != 0, a, wl, rl, $urandom, $urandom_range(0, 12),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    {a[31:5], 5'b0_0000}, 1'b0, 32'h0, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
